// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
//
// Byte-wide UART transmitter with a small input FIFO. Each byte becomes an
// 8N1 frame on the serial line: one start bit (0), eight data bits LSB
// first and one stop bit (1). Every bit lasts CLKS_PER_BIT clock cycles.
// Queued frames go out back to back with no idle gap between them.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (2 or more)
//   FIFO_DEPTH   : byte entries in the input FIFO (power of two, 2 or more)
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   reset      : asynchronous active-high reset; aborts any frame in
//                progress and empties the FIFO
//   tx_data    : byte to enqueue
//   tx_valid   : enqueue request; the byte is taken when tx_ready is high
//   tx_ready   : FIFO has room for another byte
//   tx         : registered serial output, idles high
//   busy       : a frame is currently on the line
//   fifo_count : bytes waiting in the FIFO (not counting the byte in flight)
// ---------------------------------------------------------------------------
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 3,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [7:0]                       tx_data,
    input  logic                             tx_valid,
    output logic                             tx_ready,
    output logic                             tx,
    output logic                             busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Serialiser state
    state_t           state_reg, state_next;
    logic [CYC_W-1:0] cyc_reg, cyc_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic             tx_reg, tx_next;

    // FIFO state
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic             push;
    logic             pop;
    logic             fifo_empty;

    assign fifo_empty = (count_reg == '0);
    assign tx_ready   = (count_reg != CNT_FULL);
    assign push       = tx_valid && tx_ready;

    // -----------------------------------------------------------------------
    // FIFO storage. Contents need no reset: the pointers and the count
    // define which entries are meaningful.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= tx_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 1: state register (plus the datapath registers it owns)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cyc_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            cyc_reg   <= cyc_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 2: next-state logic. The pop decision uses the registered
    // count, so a byte pushed at the same edge IDLE looks at the FIFO is
    // only popped one edge later.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cyc_next   = cyc_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        pop        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_mem[rd_ptr_reg];
                    cyc_next   = '0;
                    bit_next   = '0;
                    state_next = START;
                end
            end

            START: begin
                if (cyc_reg == CYC_LAST) begin
                    cyc_next   = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    cyc_next = cyc_reg + 1'b1;
                end
            end

            DATA: begin
                if (cyc_reg == CYC_LAST) begin
                    cyc_next = '0;
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end else begin
                    cyc_next = cyc_reg + 1'b1;
                end
            end

            STOP: begin
                if (cyc_reg == CYC_LAST) begin
                    cyc_next = '0;
                    // Chain straight into the next start bit when more
                    // data is waiting, otherwise return to idle.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_mem[rd_ptr_reg];
                        bit_next   = '0;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cyc_next = cyc_reg + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM process 3: output logic. The line level is computed from the
    // upcoming state so that the registered tx changes on the same edge as
    // the state it belongs to.
    // -----------------------------------------------------------------------
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[bit_next];
            default: tx_next = 1'b1;
        endcase
    end

    assign tx         = tx_reg;
    assign busy       = (state_reg != IDLE);
    assign fifo_count = count_reg;

endmodule

// File: tb/tb_uart_transmitter.sv
// ---------------------------------------------------------------------------
// tb_uart_transmitter
//
// Bench for uart_transmitter (CLKS_PER_BIT=3, FIFO_DEPTH=4). A frame-level
// reference model (byte queue plus position inside the current frame)
// predicts tx, busy, tx_ready and fifo_count every cycle. An independent
// line decoder rebuilds bytes from the serial output and matches them
// against the bytes the model says were accepted.
// ---------------------------------------------------------------------------
module tb_uart_transmitter;

    localparam int CPB   = 3;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;
    localparam int LIMIT = 400;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    uart_transmitter #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counters
    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model: queue of waiting bytes, byte on the line and the
    // cycle position inside its 10-bit frame.
    logic [7:0] mq[$];
    logic       m_busy = 1'b0;
    int         m_t = 0;
    logic [7:0] m_cur = 8'h00;
    logic       m_accept = 1'b0;
    logic [7:0] m_acc_byte = 8'h00;

    // Bytes accepted but not yet seen by the line decoder
    logic [7:0] sent_q[$];

    // Line decoder
    logic       dec_active = 1'b0;
    int         dec_off = 0;
    logic [7:0] dec_byte = 8'h00;

    // busy statistics over a window
    int   busy_cycles = 0;
    int   busy_falls = 0;
    logic prev_busy = 1'b0;

    int g;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h at cycle %0d", tag, obs, exp, cycle);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: timeout after %0d cycles at cycle %0d", tag, LIMIT, cycle);
    endtask

    task automatic model_reset();
        mq.delete();
        sent_q.delete();
        m_busy     = 1'b0;
        m_t        = 0;
        m_accept   = 1'b0;
        dec_active = 1'b0;
        dec_off    = 0;
    endtask

    // Advance the model across one rising edge using the pre-edge inputs.
    task automatic model_edge(input logic rst, input logic v, input logic [7:0] d);
        int pre;
        if (rst) begin
            model_reset();
            return;
        end
        pre      = mq.size();
        m_accept = v && (pre != DEPTH);
        m_acc_byte = d;
        if (!m_busy) begin
            if (pre > 0) begin
                m_cur  = mq.pop_front();
                m_busy = 1'b1;
                m_t    = 0;
            end
        end else if (m_t == FRAME - 1) begin
            if (pre > 0) begin
                m_cur = mq.pop_front();
                m_t   = 0;
            end else begin
                m_busy = 1'b0;
            end
        end else begin
            m_t++;
        end
        if (m_accept) mq.push_back(d);
    endtask

    function automatic logic exp_tx();
        int k;
        if (!m_busy) return 1'b1;
        k = m_t / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_cur[k-1];
    endfunction

    task automatic check_outputs();
        check("tx", {31'd0, tx}, {31'd0, exp_tx()});
        check("busy", {31'd0, busy}, {31'd0, m_busy});
        check("tx_ready", {31'd0, tx_ready}, (mq.size() != DEPTH) ? 32'd1 : 32'd0);
        check("fifo_count", {29'd0, fifo_count}, 32'(mq.size()));
    endtask

    task automatic decode();
        logic [7:0] e;
        if (!dec_active) begin
            if (tx === 1'b0) begin
                dec_active = 1'b1;
                dec_off    = 0;
            end
        end else begin
            dec_off++;
            for (int k = 0; k < 8; k++) begin
                if (dec_off == CPB * (k + 1) + CPB / 2) dec_byte[k] = tx;
            end
            if (dec_off == CPB * 9 + CPB / 2) begin
                check("stop_bit", {31'd0, tx}, 32'd1);
                if (sent_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL rx_extra: observed frame 0x%02h, expected no frame", dec_byte);
                end else begin
                    e = sent_q.pop_front();
                    check("rx_byte", {24'd0, dec_byte}, {24'd0, e});
                end
                $display("frame 0x%02h received at cycle %0d", dec_byte, cycle);
                dec_active = 1'b0;
            end
        end
    endtask

    task automatic step();
        model_edge(reset, tx_valid, tx_data);
        @(posedge clk);
        #1;
        cycle++;
        if (m_accept) begin
            sent_q.push_back(m_acc_byte);
            $display("push 0x%02h accepted at cycle %0d", m_acc_byte, cycle);
        end
        check_outputs();
        decode();
        if (busy === 1'b1) busy_cycles++;
        if (prev_busy === 1'b1 && busy === 1'b0) busy_falls++;
        prev_busy = busy;
    endtask

    task automatic clear_stats();
        busy_cycles = 0;
        busy_falls  = 0;
        prev_busy   = busy;
    endtask

    // Hold tx_valid with byte d until the model says there is room, then
    // take the accepting edge.
    task automatic push_hs(input logic [7:0] d);
        int n;
        n = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        while (mq.size() == DEPTH && n < LIMIT) begin
            step();
            n++;
        end
        if (n >= LIMIT) timeout("push_wait");
        step();
        tx_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        tx_valid = 1'b0;
        while ((m_busy || mq.size() != 0) && n < LIMIT) begin
            step();
            n++;
        end
        if (n >= LIMIT) timeout("drain");
        repeat (3) step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        model_reset();

        // Reset held for two cycles: idle outputs throughout
        #1;
        check_outputs();
        step();
        step();
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_ready", {31'd0, tx_ready}, 32'd1);

        // Single byte 0xD5, pushed at the first edge after release
        reset    = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'hD5;
        clear_stats();
        step();
        tx_valid = 1'b0;
        check("lat_edge_n_tx", {31'd0, tx}, 32'd1);
        check("lat_edge_n_cnt", {29'd0, fifo_count}, 32'd1);
        step();
        check("lat_edge_n1_tx", {31'd0, tx}, 32'd0);
        repeat (FRAME + 3) step();
        check("single_busy_cycles", 32'(busy_cycles), 32'(FRAME));

        // Back-to-back 0xD5, 0x33
        clear_stats();
        tx_valid = 1'b1;
        tx_data  = 8'hD5;
        step();
        tx_data  = 8'h33;
        step();
        tx_valid = 1'b0;
        repeat (2 * FRAME + 6) step();
        check("b2b_busy_cycles", 32'(busy_cycles), 32'(2 * FRAME));
        check("b2b_contiguous", 32'(busy_falls), 32'd1);

        // Full FIFO with handshake, ignored 0xAA push while full
        for (int b = 1; b <= 5; b++) push_hs(8'(b));
        check("full_count", {29'd0, fifo_count}, 32'd4);
        check("full_ready", {31'd0, tx_ready}, 32'd0);
        tx_valid = 1'b1;
        tx_data  = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ignored_push_cnt", {29'd0, fifo_count}, 32'd4);
        end
        push_hs(8'h06);
        check("push_pop_same_edge", {29'd0, fifo_count}, 32'd4);
        drain();
        check("full_all_sent", 32'(sent_q.size()), 32'd0);

        // Randomised traffic: busy phase then sparse phase
        for (int i = 0; i < 600; i++) begin
            if (i < 350) tx_valid = ($urandom_range(0, 3) == 0);
            else         tx_valid = ($urandom_range(0, 39) == 0);
            tx_data = 8'($urandom);
            step();
        end
        drain();
        check("random_all_sent", 32'(sent_q.size()), 32'd0);

        // Reset in the middle of data bit 3 of 0x0F, with 0xF0 queued
        push_hs(8'h0F);
        push_hs(8'hF0);
        g = 0;
        while (!(m_busy && m_cur == 8'h0F && m_t == CPB * 4 + 1) && g < LIMIT) begin
            step();
            g++;
        end
        if (g >= LIMIT) timeout("reach_bit3");
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs();
        check("midrst_tx", {31'd0, tx}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        step();
        step();
        reset = 1'b0;
        clear_stats();
        for (int i = 0; i < 40; i++) begin
            step();
            check("post_rst_idle", {31'd0, tx}, 32'd1);
        end
        check("post_rst_busy_cycles", 32'(busy_cycles), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter: CLKS_PER_BIT, 3, clock cycles per UART bit period; legal values are 2 or more.
REQ-002 Parameter: FIFO_DEPTH, 4, byte entries in the input FIFO; legal values are powers of two, 2 or more.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: tx_data  input  8  byte to enqueue.
REQ-006 Port: tx_valid  input  1  enqueue request for tx_data.
REQ-007 Port: tx_ready  output  1  FIFO can accept a byte; equals (fifo_count != FIFO_DEPTH), combinational from registered count.
REQ-008 Port: tx  output  1  serial line, registered; idle level is 1.
REQ-009 Port: busy  output  1  high while a frame is on the line; equals (state != IDLE).
REQ-010 Port: fifo_count  output  clog2(FIFO_DEPTH+1)  bytes currently queued, excluding the byte in flight.

Function
REQ-011 Frame format SHALL be: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity; each bit lasts exactly CLKS_PER_BIT cycles; frame length is 10*CLKS_PER_BIT cycles.
REQ-012 A push SHALL occur at a rising edge where tx_valid && tx_ready; tx_valid while tx_ready=0 SHALL be ignored, with no FIFO change.
REQ-013 The FIFO SHALL be first-in first-out, with wrap-around read/write pointers; bytes SHALL be transmitted in push order, none dropped or duplicated.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-015 IDLE: tx=1; at the edge where FIFO is non-empty, pop the head into the shift register, go to START, and drive tx=0 from that edge.
REQ-016 START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-017 DATA: drive shift[index] for CLKS_PER_BIT cycles per bit; after index 7 completes, go to STOP.
REQ-018 STOP: tx=1 for CLKS_PER_BIT cycles; at the final cycle's edge, pop and go to START if FIFO is non-empty (no idle gap), else go to IDLE.
REQ-019 Latency: a byte pushed at edge N into an empty FIFO with FSM in IDLE SHALL produce the tx falling edge at edge N+1.
REQ-020 Simultaneous push and pop at one edge SHALL leave fifo_count unchanged and store the pushed byte.
REQ-021 Push to an empty FIFO at the same edge IDLE evaluates: the byte is not popped that edge; it is popped the following edge.
REQ-022 The bit counter and cycle counter SHALL be sized for their ranges; the cycle counter resets to 0 at every bit boundary.
REQ-023 tx_data sampled at push SHALL be the byte transmitted; later tx_data changes SHALL not affect queued or in-flight bytes.

Reset
REQ-024 While reset=1, asynchronously: tx=1, busy=0, state=IDLE, fifo_count=0, pointers=0, counters=0, tx_ready=1.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately (tx=1) and flush the FIFO; no residual frame SHALL follow deassertion.
REQ-026 The first push is accepted at the first rising edge after reset deasserts.

Verification
REQ-027 Reset: assert reset 2 cycles -> tx=1, busy=0, tx_ready=1, fifo_count=0 throughout.
REQ-028 Single byte: push 0xD5 at edge N -> from edge N+1, tx = 0 (3 cycles), then bits 1,0,1,0,1,0,1,1 (3 cycles each), then 1 (3 cycles); busy high 30 cycles; then IDLE.
REQ-029 Back-to-back: push 0xD5 then 0x33 on consecutive edges -> 60 contiguous busy cycles; the start bit of 0x33 directly follows the stop bit of 0xD5; data bits of 0x33 are 1,1,0,0,1,1,0,0.
REQ-030 Full FIFO: hold tx_valid=1 with data 0x01..0x06 on successive cycles -> fifo_count reaches 4 and tx_ready=0; 0x06 is held off until the next pop; all six bytes are transmitted in order.
REQ-031 Ignored push: tx_valid=1 while tx_ready=0 with data 0xAA -> fifo_count unchanged; 0xAA is never transmitted.
REQ-032 Mid-frame reset: push 0x0F and 0xF0, then assert reset during data bit 3 of 0x0F -> tx=1 and busy=0 immediately, fifo_count=0; after release, tx stays 1 for 40 cycles.
